// File: rtl/dispatch_ctrl_pkg.sv
// ============================================================================
// Module   : dispatch_ctrl_pkg
// Purpose  : Shared types and default sizes for the dispatch controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef DISPATCH_CTRL_PKG_DEFS
`define DISPATCH_CTRL_PKG_DEFS
`define DC_ROB_SIZE_WIDTH 6
`define DC_RS_ALU_DEPTH   8
`define DC_RS_MEM_DEPTH   4
`define DC_RS_BR_DEPTH    4
`endif

package dispatch_ctrl_pkg;

  localparam int ROB_SIZE_WIDTH = `DC_ROB_SIZE_WIDTH;

  typedef enum logic [1:0] {
    RS_ALU = 2'd0,
    RS_MEM = 2'd1,
    RS_BR  = 2'd2
  } rs_class_t;

  typedef enum logic [0:0] {
    RUN        = 1'b0,
    FLUSH_HOLD = 1'b1
  } dispatch_state_t;

  typedef enum logic [1:0] {
    no_mem_op = 2'd0,
    mem_load  = 2'd1,
    mem_store = 2'd2
  } mem_op_t;

  typedef struct packed {
    mem_op_t memory_op;
    logic    is_branch_op;
  } control_t;

endpackage

`default_nettype wire

// File: rtl/dispatch_ctrl_credit.sv
// ============================================================================
// Module   : rs_credit_counter
// Purpose  : Free-entry credit counter for one reservation station.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rs_credit_counter #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_dispatch,
  input  logic                       i_release,
  input  logic                       i_flush,
  output logic [$clog2(DEPTH+1)-1:0] o_credit,
  output logic                       o_overflow
);

  localparam int W = $clog2(DEPTH + 1);
  localparam logic [W-1:0] C_FULL = W'(DEPTH);

  logic [W-1:0] r_credit;
  logic         r_overflow;
  logic         w_full;
  logic         w_empty;

  assign w_full  = (r_credit == C_FULL);
  assign w_empty = (r_credit == '0);

  // A coincident dispatch and release cancel; a lone release at full is an error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_credit   <= C_FULL;
      r_overflow <= 1'b0;
    end else if (i_flush) begin
      r_credit <= C_FULL;
    end else if (i_dispatch && !i_release) begin
      if (!w_empty) r_credit <= r_credit - W'(1);
    end else if (i_release && !i_dispatch) begin
      if (w_full) r_overflow <= 1'b1;
      else        r_credit   <= r_credit + W'(1);
    end
  end

  assign o_credit   = r_credit;
  assign o_overflow = r_overflow;

endmodule

`default_nettype wire

// File: rtl/dispatch_ctrl.sv
// ============================================================================
// Module   : dispatch_ctrl
// Purpose  : Credit-based dispatch of renamed instructions to ALU/MEM/BR stations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dispatch_ctrl
  import dispatch_ctrl_pkg::*;
#(
  parameter int RS_ALU_DEPTH          = `DC_RS_ALU_DEPTH,
  parameter int RS_MEM_DEPTH          = `DC_RS_MEM_DEPTH,
  parameter int RS_BR_DEPTH           = `DC_RS_BR_DEPTH,
  parameter int FLUSH_RECOVERY_CYCLES = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              new_valid_inst,
  input  control_t                          control,
  input  logic [ROB_SIZE_WIDTH-1:0]         inst_tag,
  input  logic                              rob_full,
  input  logic                              can_rename,
  input  logic                              flush,
  input  logic [2:0]                        rs_release,
  output logic                              stall,
  output logic [2:0]                        dispatch_valid,
  output logic [ROB_SIZE_WIDTH-1:0]         dispatch_tag,
  output logic [$clog2(RS_ALU_DEPTH+1)-1:0] credit_alu,
  output logic [$clog2(RS_MEM_DEPTH+1)-1:0] credit_mem,
  output logic [$clog2(RS_BR_DEPTH+1)-1:0]  credit_br,
  output logic [31:0]                       dispatched_count,
  output logic                              credit_overflow
);

  localparam logic [0:0] ST_RUN  = RUN;
  localparam logic [0:0] ST_HOLD = FLUSH_HOLD;
  localparam logic [3:0] C_HOLD  = 4'(FLUSH_RECOVERY_CYCLES);

  logic [0:0]  r_state;
  logic [3:0]  r_hold;
  logic [31:0] r_count;

  rs_class_t   w_class;
  logic        w_credit_zero;
  logic [2:0]  w_onehot;
  logic        w_run;
  logic        w_dispatch;
  logic [2:0]  w_disp_vec;
  logic [2:0]  w_rel_vec;
  logic [2:0]  w_ovf;

  always_comb begin
    w_class = RS_ALU;
    if (control.memory_op != no_mem_op) w_class = RS_MEM;
    else if (control.is_branch_op)      w_class = RS_BR;
  end

  always_comb begin
    w_credit_zero = 1'b0;
    w_onehot      = 3'b000;
    case (w_class)
      RS_MEM:  begin w_credit_zero = (credit_mem == '0); w_onehot = 3'b010; end
      RS_BR:   begin w_credit_zero = (credit_br  == '0); w_onehot = 3'b100; end
      default: begin w_credit_zero = (credit_alu == '0); w_onehot = 3'b001; end
    endcase
  end

  assign w_run      = (r_state == ST_RUN);
  assign stall      = w_run ? (rob_full | ~can_rename | (new_valid_inst & w_credit_zero)) : 1'b1;
  assign w_dispatch = w_run & new_valid_inst & ~stall & ~flush & ~reset;
  assign w_disp_vec = w_dispatch ? w_onehot : 3'b000;
  // Releases only count while running; a flush refills every station anyway.
  assign w_rel_vec  = (w_run & ~flush) ? rs_release : 3'b000;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_RUN;
      r_hold  <= 4'd0;
      r_count <= 32'd0;
    end else begin
      if (w_dispatch) r_count <= r_count + 32'd1;
      if (flush) begin
        r_state <= ST_HOLD;
        r_hold  <= C_HOLD;
      end else if (r_state == ST_HOLD) begin
        r_hold <= r_hold - 4'd1;
        if (r_hold <= 4'd1) r_state <= ST_RUN;
      end
    end
  end

  rs_credit_counter #(.DEPTH(RS_ALU_DEPTH)) u_credit_alu (
    .clk(clk), .reset(reset), .i_dispatch(w_disp_vec[RS_ALU]), .i_release(w_rel_vec[RS_ALU]),
    .i_flush(flush), .o_credit(credit_alu), .o_overflow(w_ovf[RS_ALU]));

  rs_credit_counter #(.DEPTH(RS_MEM_DEPTH)) u_credit_mem (
    .clk(clk), .reset(reset), .i_dispatch(w_disp_vec[RS_MEM]), .i_release(w_rel_vec[RS_MEM]),
    .i_flush(flush), .o_credit(credit_mem), .o_overflow(w_ovf[RS_MEM]));

  rs_credit_counter #(.DEPTH(RS_BR_DEPTH)) u_credit_br (
    .clk(clk), .reset(reset), .i_dispatch(w_disp_vec[RS_BR]), .i_release(w_rel_vec[RS_BR]),
    .i_flush(flush), .o_credit(credit_br), .o_overflow(w_ovf[RS_BR]));

  assign dispatch_valid   = w_disp_vec;
  assign dispatch_tag     = inst_tag;
  assign dispatched_count = r_count;
  assign credit_overflow  = |w_ovf;

endmodule

`default_nettype wire

// File: tb/tb_dispatch_ctrl.sv
// ============================================================================
// Module   : tb_dispatch_ctrl
// Purpose  : Directed self-checking bench for dispatch_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dispatch_ctrl;
  import dispatch_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic new_valid_inst = 1'b0;
  logic rob_full = 1'b0;
  logic can_rename = 1'b1;
  logic flush = 1'b0;
  logic [2:0] rs_release = 3'b000;
  control_t control = '{memory_op: no_mem_op, is_branch_op: 1'b0};
  logic [ROB_SIZE_WIDTH-1:0] inst_tag = '0;

  logic        stall;
  logic [2:0]  dispatch_valid;
  logic [ROB_SIZE_WIDTH-1:0] dispatch_tag;
  logic [3:0]  credit_alu;
  logic [2:0]  credit_mem;
  logic [2:0]  credit_br;
  logic [31:0] dispatched_count;
  logic        credit_overflow;

  int n_cmp = 0;
  int n_fail = 0;

  dispatch_ctrl dut (
    .clk(clk), .reset(reset), .new_valid_inst(new_valid_inst), .control(control),
    .inst_tag(inst_tag), .rob_full(rob_full), .can_rename(can_rename), .flush(flush),
    .rs_release(rs_release), .stall(stall), .dispatch_valid(dispatch_valid),
    .dispatch_tag(dispatch_tag), .credit_alu(credit_alu), .credit_mem(credit_mem),
    .credit_br(credit_br), .dispatched_count(dispatched_count), .credit_overflow(credit_overflow));

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_inst(input logic v, input rs_class_t c, input int tag);
    new_valid_inst       = v;
    control.memory_op    = (c == RS_MEM) ? mem_load : no_mem_op;
    control.is_branch_op = (c == RS_BR);
    inst_tag             = ROB_SIZE_WIDTH'(tag);
  endtask

  task automatic test_reset;
    set_inst(1'b1, RS_ALU, 1);
    step; step;
    n_cmp++; if (dispatch_valid !== 3'b000) begin n_fail++; $display("FAIL reset_dv: got %b want 000", dispatch_valid); end
    n_cmp++; if (credit_alu !== 4'd8) begin n_fail++; $display("FAIL reset_alu: got %0d want 8", credit_alu); end
    n_cmp++; if (credit_mem !== 3'd4 || credit_br !== 3'd4) begin n_fail++; $display("FAIL reset_mem_br: got %0d/%0d want 4/4", credit_mem, credit_br); end
    n_cmp++; if (dispatched_count !== 32'd0 || credit_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_cnt_ovf: got %0d/%b want 0/0", dispatched_count, credit_overflow); end
    set_inst(1'b0, RS_ALU, 0);
    reset = 1'b0;
  endtask

  task automatic test_mem_burst;
    for (int i = 0; i < 4; i++) begin
      set_inst(1'b1, RS_MEM, i + 10);
      #1;
      n_cmp++; if (dispatch_valid !== 3'b010 || stall !== 1'b0) begin n_fail++; $display("FAIL mem_burst_dv[%0d]: got %b/%b want 010/0", i, dispatch_valid, stall); end
      n_cmp++; if (dispatch_tag !== ROB_SIZE_WIDTH'(i + 10)) begin n_fail++; $display("FAIL mem_burst_tag[%0d]: got %0d want %0d", i, dispatch_tag, i + 10); end
      n_cmp++; if (credit_mem !== 3'(4 - i)) begin n_fail++; $display("FAIL mem_burst_credit[%0d]: got %0d want %0d", i, credit_mem, 4 - i); end
      step;
    end
    set_inst(1'b1, RS_MEM, 14);
    #1;
    n_cmp++; if (stall !== 1'b1 || dispatch_valid !== 3'b000) begin n_fail++; $display("FAIL mem_exhaust: got stall=%b dv=%b want 1/000", stall, dispatch_valid); end
    n_cmp++; if (credit_mem !== 3'd0 || dispatched_count !== 32'd4) begin n_fail++; $display("FAIL mem_exhaust_cnt: got %0d/%0d want 0/4", credit_mem, dispatched_count); end
  endtask

  task automatic test_release_unblock;
    rs_release = 3'b010;
    #1;
    n_cmp++; if (stall !== 1'b1 || dispatch_valid !== 3'b000) begin n_fail++; $display("FAIL rel_same_cycle: got %b/%b want 1/000", stall, dispatch_valid); end
    step;
    rs_release = 3'b000;
    #1;
    n_cmp++; if (credit_mem !== 3'd1) begin n_fail++; $display("FAIL rel_credit: got %0d want 1", credit_mem); end
    n_cmp++; if (stall !== 1'b0 || dispatch_valid !== 3'b010) begin n_fail++; $display("FAIL rel_dispatch: got %b/%b want 0/010", stall, dispatch_valid); end
    step;
    set_inst(1'b0, RS_ALU, 0);
    #1;
    n_cmp++; if (credit_mem !== 3'd0 || dispatched_count !== 32'd5) begin n_fail++; $display("FAIL rel_after: got %0d/%0d want 0/5", credit_mem, dispatched_count); end
  endtask

  task automatic test_same_cycle_alu;
    for (int i = 0; i < 3; i++) begin
      set_inst(1'b1, RS_ALU, i);
      step;
    end
    #1;
    n_cmp++; if (credit_alu !== 4'd5) begin n_fail++; $display("FAIL alu_pre: got %0d want 5", credit_alu); end
    set_inst(1'b1, RS_ALU, 9);
    rs_release = 3'b001;
    #1;
    n_cmp++; if (dispatch_valid !== 3'b001) begin n_fail++; $display("FAIL alu_same_dv: got %b want 001", dispatch_valid); end
    step;
    rs_release = 3'b000;
    set_inst(1'b0, RS_ALU, 0);
    #1;
    n_cmp++; if (credit_alu !== 4'd5 || dispatched_count !== 32'd9) begin n_fail++; $display("FAIL alu_same_credit: got %0d/%0d want 5/9", credit_alu, dispatched_count); end
  endtask

  task automatic test_flush;
    for (int i = 0; i < 3; i++) begin
      set_inst(1'b1, RS_ALU, i);
      step;
    end
    set_inst(1'b0, RS_ALU, 0);
    rs_release = 3'b010;
    step;
    rs_release = 3'b000;
    set_inst(1'b1, RS_BR, 7);
    step;
    set_inst(1'b0, RS_ALU, 0);
    #1;
    n_cmp++; if (credit_alu !== 4'd2 || credit_mem !== 3'd1 || credit_br !== 3'd3) begin n_fail++; $display("FAIL flush_pre: got %0d,%0d,%0d want 2,1,3", credit_alu, credit_mem, credit_br); end
    flush = 1'b1;
    set_inst(1'b1, RS_ALU, 3);
    #1;
    n_cmp++; if (dispatch_valid !== 3'b000) begin n_fail++; $display("FAIL flush_dv: got %b want 000", dispatch_valid); end
    step;
    flush = 1'b0;
    rs_release = 3'b001;
    #1;
    n_cmp++; if (stall !== 1'b1 || dispatch_valid !== 3'b000) begin n_fail++; $display("FAIL hold1: got %b/%b want 1/000", stall, dispatch_valid); end
    n_cmp++; if (credit_alu !== 4'd8 || credit_mem !== 3'd4 || credit_br !== 3'd4) begin n_fail++; $display("FAIL flush_refill: got %0d,%0d,%0d want 8,4,4", credit_alu, credit_mem, credit_br); end
    step;
    rs_release = 3'b000;
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_fail++; $display("FAIL hold2: got %b want 1", stall); end
    step;
    #1;
    n_cmp++; if (stall !== 1'b0 || dispatch_valid !== 3'b001) begin n_fail++; $display("FAIL hold_exit: got %b/%b want 0/001", stall, dispatch_valid); end
    set_inst(1'b0, RS_ALU, 0);
    #1;
    n_cmp++; if (credit_alu !== 4'd8 || credit_overflow !== 1'b0) begin n_fail++; $display("FAIL hold_release_ignored: got %0d/%b want 8/0", credit_alu, credit_overflow); end
    // Second flush lands on the first hold cycle and restarts the count.
    flush = 1'b1;
    step;
    flush = 1'b0;
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_fail++; $display("FAIL reflush_h1: got %b want 1", stall); end
    flush = 1'b1;
    step;
    flush = 1'b0;
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_fail++; $display("FAIL reflush_a1: got %b want 1", stall); end
    step;
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_fail++; $display("FAIL reflush_a2: got %b want 1", stall); end
    step;
    #1;
    n_cmp++; if (stall !== 1'b0 || dispatched_count !== 32'd13) begin n_fail++; $display("FAIL reflush_exit: got %b/%0d want 0/13", stall, dispatched_count); end
  endtask

  task automatic test_overflow;
    rs_release = 3'b100;
    step;
    rs_release = 3'b000;
    #1;
    n_cmp++; if (credit_br !== 3'd4 || credit_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %0d/%b want 4/1", credit_br, credit_overflow); end
    step; step;
    #1;
    n_cmp++; if (credit_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", credit_overflow); end
  endtask

  task automatic test_stall_conditions;
    rob_full = 1'b1;
    set_inst(1'b1, RS_ALU, 5);
    #1;
    n_cmp++; if (stall !== 1'b1 || dispatch_valid !== 3'b000) begin n_fail++; $display("FAIL rob_full: got %b/%b want 1/000", stall, dispatch_valid); end
    step;
    rob_full = 1'b0;
    can_rename = 1'b0;
    #1;
    n_cmp++; if (stall !== 1'b1 || dispatch_valid !== 3'b000) begin n_fail++; $display("FAIL no_rename: got %b/%b want 1/000", stall, dispatch_valid); end
    step;
    can_rename = 1'b1;
    set_inst(1'b0, RS_ALU, 0);
    #1;
    n_cmp++; if (credit_alu !== 4'd8 || dispatched_count !== 32'd13) begin n_fail++; $display("FAIL stall_unchanged: got %0d/%0d want 8/13", credit_alu, dispatched_count); end
    for (int i = 0; i < 8; i++) begin
      set_inst(1'b1, RS_ALU, i);
      step;
    end
    rob_full = 1'b1;
    #1;
    n_cmp++; if (stall !== 1'b1 || dispatch_valid !== 3'b000 || credit_alu !== 4'd0) begin n_fail++; $display("FAIL rob_and_empty: got %b/%b/%0d want 1/000/0", stall, dispatch_valid, credit_alu); end
    step;
    rob_full = 1'b0;
    set_inst(1'b0, RS_ALU, 0);
    #1;
    n_cmp++; if (credit_alu !== 4'd0 || dispatched_count !== 32'd21) begin n_fail++; $display("FAIL rob_and_empty_cnt: got %0d/%0d want 0/21", credit_alu, dispatched_count); end
  endtask

  task automatic test_reset_during_hold;
    flush = 1'b1;
    step;
    flush = 1'b0;
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_fail++; $display("FAIL rst_hold_pre: got %b want 1", stall); end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (stall !== 1'b0 || dispatched_count !== 32'd0 || credit_overflow !== 1'b0) begin n_fail++; $display("FAIL rst_hold_abort: got %b/%0d/%b want 0/0/0", stall, dispatched_count, credit_overflow); end
    step;
    reset = 1'b0;
    set_inst(1'b1, RS_BR, 2);
    #1;
    n_cmp++; if (dispatch_valid !== 3'b100) begin n_fail++; $display("FAIL rst_first_dispatch: got %b want 100", dispatch_valid); end
    step;
    set_inst(1'b0, RS_ALU, 0);
    #1;
    n_cmp++; if (dispatched_count !== 32'd1 || credit_br !== 3'd3) begin n_fail++; $display("FAIL rst_after: got %0d/%0d want 1/3", dispatched_count, credit_br); end
  endtask

  initial begin
    test_reset;
    test_mem_burst;
    test_release_unblock;
    test_same_cycle_alu;
    test_flush;
    test_overflow;
    test_stall_conditions;
    test_reset_during_hold;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
